// File: rtl/status_reg_pkg.sv
// Shared constants for the processor status register: flag bit positions, flag_op codes,
// the stored-flag record and its reset value.
package status_reg_pkg;

   localparam int unsigned CARRY = 0;
   localparam int unsigned ZERO  = 1;
   localparam int unsigned IRQ   = 2;
   localparam int unsigned DEC   = 3;
   localparam int unsigned BRK   = 4;
   localparam int unsigned ONE   = 5;
   localparam int unsigned OVF   = 6;
   localparam int unsigned NEG   = 7;

   localparam logic [2:0] FLAG_CLC = 3'd0;
   localparam logic [2:0] FLAG_SEC = 3'd1;
   localparam logic [2:0] FLAG_CLI = 3'd2;
   localparam logic [2:0] FLAG_SEI = 3'd3;
   localparam logic [2:0] FLAG_CLD = 3'd4;
   localparam logic [2:0] FLAG_SED = 3'd5;
   localparam logic [2:0] FLAG_CLV = 3'd6;
   localparam logic [2:0] FLAG_NOP = 3'd7;

   typedef struct packed {
      logic n;
      logic v;
      logic d;
      logic i;
      logic z;
      logic c;
   } flags_t;

   // Reset image is P = 8'h24: only I set among the stored flags.
   localparam flags_t FLAGS_RESET = flags_t'(6'b000100);

   // Assemble the architectural P byte; bit 5 reads as 1, bit 4 (B) as 0.
   function automatic logic [7:0] pack_p(flags_t f);
      logic [7:0] p;
      p        = '0;
      p[NEG]   = f.n;
      p[OVF]   = f.v;
      p[ONE]   = 1'b1;
      p[DEC]   = f.d;
      p[IRQ]   = f.i;
      p[ZERO]  = f.z;
      p[CARRY] = f.c;
      return p;
   endfunction

endpackage

// File: rtl/status_reg.sv
// 6502-style status register: prioritised flag commits, push image and change pulse.
// Define DECIMAL_MODE_EN to make the D flag writable; otherwise D is tied to 0.
module status_reg
   import status_reg_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] alu_Y,
   input  logic       alu_carry_out,
   input  logic       alu_overflow,
   input  logic       upd_valid,
   input  logic [3:0] upd_mask,
   input  logic       bit_valid,
   input  logic [7:0] bit_mem,
   input  logic       flag_op_valid,
   input  logic [2:0] flag_op,
   input  logic       pull_valid,
   input  logic [7:0] pull_data,
   input  logic       int_entry,
   input  logic       push_brk,
   output logic [7:0] p_reg,
   output logic [7:0] p_push,
   output logic       flag_c,
   output logic       p_changed
);

   flags_t flags_q, flags_d;
   logic   changed_q;

   // Bits 5 and 4 of a pulled byte have no storage behind them.
   logic unused_pull_bits;
   assign unused_pull_bits = ^pull_data[5:4];

   always_comb begin
      flags_d = flags_q;
      if (pull_valid) begin
         flags_d.n = pull_data[NEG];
         flags_d.v = pull_data[OVF];
         flags_d.d = pull_data[DEC];
         flags_d.i = pull_data[IRQ];
         flags_d.z = pull_data[ZERO];
         flags_d.c = pull_data[CARRY];
      end else if (int_entry || flag_op_valid) begin
         if (flag_op_valid) begin
            case (flag_op)
               FLAG_CLC: flags_d.c = 1'b0;
               FLAG_SEC: flags_d.c = 1'b1;
               FLAG_CLI: flags_d.i = 1'b0;
               FLAG_SEI: flags_d.i = 1'b1;
               FLAG_CLD: flags_d.d = 1'b0;
               FLAG_SED: flags_d.d = 1'b1;
               FLAG_CLV: flags_d.v = 1'b0;
               FLAG_NOP: ;
            endcase
         end
         // Interrupt entry is applied after the flag op, so CLI cannot win.
         if (int_entry) begin
            flags_d.i = 1'b1;
         end
      end else if (bit_valid) begin
         flags_d.n = bit_mem[7];
         flags_d.v = bit_mem[6];
         flags_d.z = (alu_Y == 8'h00);
      end else if (upd_valid) begin
         if (upd_mask[3]) flags_d.n = alu_Y[7];
         if (upd_mask[2]) flags_d.v = alu_overflow;
         if (upd_mask[1]) flags_d.z = (alu_Y == 8'h00);
         if (upd_mask[0]) flags_d.c = alu_carry_out;
      end
`ifndef DECIMAL_MODE_EN
      flags_d.d = 1'b0;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flags_q   <= FLAGS_RESET;
         changed_q <= 1'b0;
      end else begin
         flags_q   <= flags_d;
         changed_q <= (flags_d != flags_q);
      end
   end

   assign p_reg     = pack_p(flags_q);
   assign flag_c    = flags_q.c;
   assign p_changed = changed_q;

   always_comb begin
      p_push      = p_reg;
      p_push[BRK] = push_brk;
   end

endmodule

// File: tb/tb_status_reg.sv
// Self-checking bench for status_reg: directed scenarios plus randomized traffic against a
// byte-level model of P. Honours DECIMAL_MODE_EN the same way the design does.
module tb_status_reg;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] alu_Y = '0;
   logic       alu_carry_out = 1'b0;
   logic       alu_overflow = 1'b0;
   logic       upd_valid = 1'b0;
   logic [3:0] upd_mask = '0;
   logic       bit_valid = 1'b0;
   logic [7:0] bit_mem = '0;
   logic       flag_op_valid = 1'b0;
   logic [2:0] flag_op = '0;
   logic       pull_valid = 1'b0;
   logic [7:0] pull_data = '0;
   logic       int_entry = 1'b0;
   logic       push_brk = 1'b0;
   logic [7:0] p_reg, p_push;
   logic       flag_c, p_changed;

   int unsigned n_checks = 0;
   int unsigned n_fail = 0;
   logic [7:0] model_p = 8'h24;

`ifdef DECIMAL_MODE_EN
   localparam bit DecOn = 1'b1;
`else
   localparam bit DecOn = 1'b0;
`endif

   status_reg dut (
      .clk           (clk),
      .rst           (rst),
      .alu_Y         (alu_Y),
      .alu_carry_out (alu_carry_out),
      .alu_overflow  (alu_overflow),
      .upd_valid     (upd_valid),
      .upd_mask      (upd_mask),
      .bit_valid     (bit_valid),
      .bit_mem       (bit_mem),
      .flag_op_valid (flag_op_valid),
      .flag_op       (flag_op),
      .pull_valid    (pull_valid),
      .pull_data     (pull_data),
      .int_entry     (int_entry),
      .push_brk      (push_brk),
      .p_reg         (p_reg),
      .p_push        (p_push),
      .flag_c        (flag_c),
      .p_changed     (p_changed)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h expected %02h", tag, got, exp);
      end
   endtask

   // Next P from the current inputs, written as byte-level rules on the visible P image.
   function automatic logic [7:0] model_next(input logic [7:0] p);
      logic [7:0] n;
      n = p;
      if (pull_valid) begin
         n = (pull_data | 8'h20) & 8'hEF;
         if (!DecOn) n[3] = 1'b0;
      end else if (int_entry || flag_op_valid) begin
         if (flag_op_valid) begin
            case (flag_op)
               3'd0: n = n & 8'hFE;
               3'd1: n = n | 8'h01;
               3'd2: n = n & 8'hFB;
               3'd3: n = n | 8'h04;
               3'd4: n = n & 8'hF7;
               3'd5: if (DecOn) n = n | 8'h08;
               3'd6: n = n & 8'hBF;
               default: n = n;
            endcase
         end
         if (int_entry) n = n | 8'h04;
      end else if (bit_valid) begin
         n = {bit_mem[7:6], n[5:2], (alu_Y == 8'h00), n[0]};
      end else if (upd_valid) begin
         if (upd_mask[3]) n[7] = alu_Y[7];
         if (upd_mask[2]) n[6] = alu_overflow;
         if (upd_mask[1]) n[1] = (alu_Y == 8'h00);
         if (upd_mask[0]) n[0] = alu_carry_out;
      end
      return n;
   endfunction

   task automatic idle_inputs();
      upd_valid = 1'b0; bit_valid = 1'b0; flag_op_valid = 1'b0;
      pull_valid = 1'b0; int_entry = 1'b0;
   endtask

   // Called at a negedge with inputs set; clocks one edge and checks all outputs.
   task automatic step(input string tag);
      logic [7:0] exp;
      logic       exp_chg;
      exp     = model_next(model_p);
      exp_chg = (exp != model_p);
      @(posedge clk);
      #1;
      model_p = exp;
      check({tag, ".p_reg"}, p_reg, exp);
      check({tag, ".p_changed"}, {7'b0, p_changed}, {7'b0, exp_chg});
      check({tag, ".flag_c"}, {7'b0, flag_c}, {7'b0, exp[0]});
      check({tag, ".p_push"}, p_push, {exp[7:6], 1'b1, push_brk, exp[3:0]});
      @(negedge clk);
   endtask

   // Called at a negedge; asserts rst mid-cycle, holds it across one edge, releases at negedge.
   task automatic pulse_reset(input string tag);
      #2 rst = 1'b1;
      #1;
      check({tag, ".async_p"}, p_reg, 8'h24);
      check({tag, ".async_chg"}, {7'b0, p_changed}, 8'h00);
      check({tag, ".async_c"}, {7'b0, flag_c}, 8'h00);
      @(posedge clk);
      #1;
      check({tag, ".held_p"}, p_reg, 8'h24);
      @(negedge clk);
      rst = 1'b0;
      model_p = 8'h24;
   endtask

   initial begin
      @(negedge clk);
      #1;
      check("init_reset.p", p_reg, 8'h24);
      @(negedge clk);
      rst = 1'b0;

      // Reset with a commit in flight: commit is discarded, reset value held after release.
      upd_valid = 1'b1; upd_mask = 4'hF; alu_Y = 8'h80; alu_carry_out = 1'b1;
      alu_overflow = 1'b1;
      pulse_reset("rst_inflight");
      idle_inputs();
      step("rst_release");
      check("rst_release.const", p_reg, 8'h24);

      // Full ALU commit, then the change pulse must drop.
      upd_valid = 1'b1; upd_mask = 4'hF; alu_Y = 8'h00; alu_carry_out = 1'b1;
      alu_overflow = 1'b1;
      step("alu_full");
      check("alu_full.const", p_reg, 8'h67);
      idle_inputs();
      step("alu_pulse_drop");
      check("alu_pulse_drop.const", {7'b0, p_changed}, 8'h00);

      // Masked commit: only C follows.
      pulse_reset("rst2");
      upd_valid = 1'b1; upd_mask = 4'b0001; alu_Y = 8'h80; alu_carry_out = 1'b1;
      alu_overflow = 1'b0;
      step("alu_masked");
      check("alu_masked.const", p_reg, 8'h25);
      idle_inputs();

      // Pull wins over interrupt entry and CLC.
      pull_valid = 1'b1; pull_data = 8'hFF; int_entry = 1'b1; flag_op_valid = 1'b1;
      flag_op = 3'd0;
      step("prio_pull");
      check("prio_pull.const", p_reg, DecOn ? 8'hEF : 8'hE7);
      idle_inputs();

      // Interrupt entry merged with CLI and with SEC, each from P=20.
      pull_valid = 1'b1; pull_data = 8'h20;
      step("load20a");
      idle_inputs();
      int_entry = 1'b1; flag_op_valid = 1'b1; flag_op = 3'd2;
      step("merge_cli");
      check("merge_cli.const", p_reg, 8'h24);
      idle_inputs();
      pull_valid = 1'b1; pull_data = 8'h20;
      step("load20b");
      idle_inputs();
      int_entry = 1'b1; flag_op_valid = 1'b1; flag_op = 3'd1;
      step("merge_sec");
      check("merge_sec.const", p_reg, 8'h25);
      idle_inputs();

      // BIT commit and push image.
      pulse_reset("rst3");
      bit_valid = 1'b1; bit_mem = 8'hC0; alu_Y = 8'h00; push_brk = 1'b1;
      step("bit_op");
      check("bit_op.const", p_reg, 8'hE6);
      check("bit_push.const", p_push, 8'hF6);
      idle_inputs();
      push_brk = 1'b0;
      #1;
      check("push_nobrk", p_push, 8'hE6);

      // SED then CLD exercise the D configuration.
      flag_op_valid = 1'b1; flag_op = 3'd5;
      step("sed");
      flag_op = 3'd4;
      step("cld");
      idle_inputs();

      // Randomized traffic with occasional asynchronous resets.
      for (int i = 0; i < 400; i++) begin
         alu_Y         = 8'($urandom);
         if ($urandom_range(0, 3) == 0) alu_Y = 8'h00;
         alu_carry_out = 1'($urandom);
         alu_overflow  = 1'($urandom);
         upd_valid     = ($urandom_range(0, 1) == 0);
         upd_mask      = 4'($urandom);
         bit_valid     = ($urandom_range(0, 3) == 0);
         bit_mem       = 8'($urandom);
         flag_op_valid = ($urandom_range(0, 3) == 0);
         flag_op       = 3'($urandom);
         pull_valid    = ($urandom_range(0, 7) == 0);
         pull_data     = 8'($urandom);
         int_entry     = ($urandom_range(0, 7) == 0);
         push_brk      = 1'($urandom);
         if ($urandom_range(0, 49) == 0) begin
            pulse_reset("rand_rst");
         end else begin
            step("rand");
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete, expected finish before 200000");
      $fatal(1);
   end

endmodule
